// File: rtl/mux_arb_pkg.sv
// rtl/mux_arb_pkg.sv - shared types and constants for the round-robin mux arbiter
//
// Purpose : FSM state enum, requester count, select width and the default
//           burst hold limit used by mux_rr_arbiter and rr_pick.
// Ports   : none (package).
package mux_arb_pkg;

  localparam int N_REQ        = 4;
  localparam int SEL_W        = 2;
  localparam int MAX_HOLD_DEF = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational rotate-priority picker for four requesters
//
// Purpose : finds the first set request bit scanning Ptr, Ptr+1, ... mod 4.
// Ports   : Req    [3:0] in  - request vector
//           Ptr    [1:0] in  - index holding highest priority
//           Any          out - at least one request set
//           Idx    [1:0] out - index of winner (Ptr when Any=0)
//           Onehot [3:0] out - one-hot winner, zero when Any=0
module rr_pick
  import mux_arb_pkg::*;
(
  input  logic [N_REQ-1:0] Req,
  input  logic [SEL_W-1:0] Ptr,
  output logic             Any,
  output logic [SEL_W-1:0] Idx,
  output logic [N_REQ-1:0] Onehot
);

  logic [SEL_W-1:0] cand;

  // Scan from the farthest offset down to offset 0 so the nearest set bit
  // (lowest offset from Ptr) is the last one written and therefore wins.
  always_comb begin
    Any    = 1'b0;
    Idx    = Ptr;
    Onehot = '0;
    cand   = Ptr;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      cand = Ptr + SEL_W'(i);
      if (Req[cand]) begin
        Any = 1'b1;
        Idx = cand;
      end
    end
    if (Any) begin
      Onehot[Idx] = 1'b1;
    end
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// rtl/mux_rr_arbiter.sv - round-robin arbiter driving a shared 4:1 data mux
//
// Purpose : grants one of four requesters for a burst, forwards its lane to a
//           single valid/ready output, then rotates priority past the winner.
// Optional: MUX_ARB_HOLD_LIMIT_EN - when defined, a burst also ends on the
//           transfer that brings the per-burst count to MAX_HOLD.
// Ports   : Clk                    in  - clock, rising edge
//           Rst_n                  in  - asynchronous active-low reset
//           Req       [3:0]        in  - per-requester request
//           Last      [3:0]        in  - per-requester end-of-burst flag
//           Data_in   [4*DATA_W-1] in  - packed lanes, lane k at k*DATA_W
//           Ready_in               in  - downstream ready
//           Gnt       [3:0]        out - registered one-hot grant
//           Sel       [1:0]        out - registered mux select
//           Valid_out              out - Data_out valid
//           Data_out  [DATA_W-1:0] out - selected lane
module mux_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int MAX_HOLD = MAX_HOLD_DEF
) (
  input  logic                    Clk,
  input  logic                    Rst_n,
  input  logic [N_REQ-1:0]        Req,
  input  logic [N_REQ-1:0]        Last,
  input  logic [N_REQ*DATA_W-1:0] Data_in,
  input  logic                    Ready_in,
  output logic [N_REQ-1:0]        Gnt,
  output logic [SEL_W-1:0]        Sel,
  output logic                    Valid_out,
  output logic [DATA_W-1:0]       Data_out
);

  if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("mux_rr_arbiter: MAX_HOLD must be in 1..255");
  end

  state_e           state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;

  logic             pick_any;
  logic [SEL_W-1:0] pick_idx;
  logic [N_REQ-1:0] pick_onehot;

  logic valid;
  logic xfer;
  logic burst_end;
  logic hold_hit;

  rr_pick u_pick (
    .Req    (Req),
    .Ptr    (ptr_q),
    .Any    (pick_any),
    .Idx    (pick_idx),
    .Onehot (pick_onehot)
  );

  assign valid     = (state_q == GRANT) && Req[sel_q];
  assign xfer      = valid && Ready_in;
  assign Valid_out = valid;
  assign Gnt       = gnt_q;
  assign Sel       = sel_q;
  assign Data_out  = Data_in[int'(sel_q) * DATA_W +: DATA_W];

`ifdef MUX_ARB_HOLD_LIMIT_EN
  localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD);

  logic [7:0] hold_q, hold_d;

  // Limit is hit by the transfer that would make the count equal MAX_HOLD.
  assign hold_hit = xfer && ((hold_q + 8'd1) == HOLD_LIM);

  always_comb begin
    hold_d = hold_q;
    if (burst_end) begin
      hold_d = '0;
    end else if (xfer) begin
      hold_d = hold_q + 8'd1;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      hold_q <= '0;
    end else begin
      hold_q <= hold_d;
    end
  end
`else
  assign hold_hit = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    sel_d     = sel_q;
    ptr_d     = ptr_q;
    burst_end = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d = GRANT;
          gnt_d   = pick_onehot;
          sel_d   = pick_idx;
        end
      end
      GRANT: begin
        // Withdrawal with no transfer: valid is low, so xfer is low too.
        burst_end = (xfer && Last[sel_q]) || !Req[sel_q] || hold_hit;
        if (burst_end) begin
          state_d = IDLE;
          gnt_d   = '0;
          ptr_d   = sel_q + SEL_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      sel_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
    end
  end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// tb/tb_mux_rr_arbiter.sv - self-checking bench for mux_rr_arbiter
module tb_mux_rr_arbiter;

  localparam int DW   = 8;
  localparam int HOLD = 4;

  logic          Clk;
  logic          Rst_n;
  logic [3:0]    Req;
  logic [3:0]    Last;
  logic [4*DW-1:0] Data_in;
  logic          Ready_in;
  logic [3:0]    Gnt;
  logic [1:0]    Sel;
  logic          Valid_out;
  logic [DW-1:0] Data_out;

  int n_tests = 0;
  int n_fail  = 0;

  mux_rr_arbiter #(.DATA_W(DW), .MAX_HOLD(HOLD)) dut (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .Req       (Req),
    .Last      (Last),
    .Data_in   (Data_in),
    .Ready_in  (Ready_in),
    .Gnt       (Gnt),
    .Sel       (Sel),
    .Valid_out (Valid_out),
    .Data_out  (Data_out)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    bit       rst;
    bit [3:0] req;
    bit [3:0] last;
    bit       rdy;
    bit [3:0] gnt;
    bit [1:0] sel;
    bit       vld;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input bit rst, input bit [3:0] req, input bit [3:0] last,
                     input bit rdy, input bit [3:0] gnt, input bit [1:0] sel,
                     input bit vld);
    vec_t v;
    v.rst = rst; v.req = req; v.last = last; v.rdy = rdy;
    v.gnt = gnt; v.sel = sel; v.vld = vld;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %0h, expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic do_reset();
    Rst_n    = 1'b0;
    Req      = '0;
    Last     = '0;
    Ready_in = 1'b0;
    @(posedge Clk);
    @(posedge Clk);
    #1;
    Rst_n = 1'b1;
  endtask

  // Behavioural reference: granted index (-1 = none), priority pointer, count.
  int m_gnt, m_sel, m_ptr, m_cnt;

  task automatic model_reset();
    m_gnt = -1; m_sel = 0; m_ptr = 0; m_cnt = 0;
  endtask

  function automatic bit [DW-1:0] lane(input int k);
    return Data_in[k*DW +: DW];
  endfunction

  task automatic model_step(input bit [3:0] req, input bit [3:0] last, input bit rdy);
    bit v, x, fin;
    if (m_gnt < 0) begin
      for (int off = 0; off < 4; off++) begin
        int c;
        c = (m_ptr + off) % 4;
        if (req[c]) begin
          m_gnt = c;
          m_sel = c;
          break;
        end
      end
    end else begin
      v   = req[m_gnt];
      x   = v && rdy;
      if (x) m_cnt++;
      fin = (x && last[m_gnt]) || !v;
`ifdef MUX_ARB_HOLD_LIMIT_EN
      if (x && m_cnt == HOLD) fin = 1'b1;
`endif
      if (fin) begin
        m_ptr = (m_gnt + 1) % 4;
        m_gnt = -1;
        m_cnt = 0;
      end
    end
  endtask

  initial begin
    bit [3:0] egnt;
    bit       evld;

    Data_in = {8'hA3, 8'hA2, 8'hA1, 8'hA0};

    // Two requesters, one-beat bursts: 0 then 2 after a bubble.
    add(1, 4'b0101, 4'b1111, 1, 4'b0000, 0, 0);
    add(0, 4'b0101, 4'b1111, 1, 4'b0001, 0, 1);
    add(0, 4'b0101, 4'b1111, 1, 4'b0000, 0, 0);
    add(0, 4'b0101, 4'b1111, 1, 4'b0100, 2, 1);
    add(0, 4'b0000, 4'b0000, 1, 4'b0000, 2, 0);
    // All requesting: 0,1,2,3,0 with wrap.
    add(1, 4'b1111, 4'b1111, 1, 4'b0000, 0, 0);
    add(0, 4'b1111, 4'b1111, 1, 4'b0001, 0, 1);
    add(0, 4'b1111, 4'b1111, 1, 4'b0000, 0, 0);
    add(0, 4'b1111, 4'b1111, 1, 4'b0010, 1, 1);
    add(0, 4'b1111, 4'b1111, 1, 4'b0000, 1, 0);
    add(0, 4'b1111, 4'b1111, 1, 4'b0100, 2, 1);
    add(0, 4'b1111, 4'b1111, 1, 4'b0000, 2, 0);
    add(0, 4'b1111, 4'b1111, 1, 4'b1000, 3, 1);
    add(0, 4'b1111, 4'b1111, 1, 4'b0000, 3, 0);
    add(0, 4'b1111, 4'b1111, 1, 4'b0001, 0, 1);
    // Stall: requester 1 held 3 cycles with Ready_in low.
    add(1, 4'b0010, 4'b0010, 0, 4'b0000, 0, 0);
    add(0, 4'b0010, 4'b0010, 0, 4'b0010, 1, 1);
    add(0, 4'b0010, 4'b0010, 0, 4'b0010, 1, 1);
    add(0, 4'b0010, 4'b0010, 0, 4'b0010, 1, 1);
    add(0, 4'b0010, 4'b0010, 1, 4'b0010, 1, 1);
    add(0, 4'b0000, 4'b0000, 1, 4'b0000, 1, 0);
    // Withdrawal by requester 3: pointer wraps to 0.
    add(1, 4'b1000, 4'b0000, 1, 4'b0000, 0, 0);
    add(0, 4'b1000, 4'b0000, 1, 4'b1000, 3, 1);
    add(0, 4'b0000, 4'b0000, 1, 4'b1000, 3, 0);
    add(0, 4'b1001, 4'b0000, 1, 4'b0000, 3, 0);
    add(0, 4'b1001, 4'b0001, 1, 4'b0001, 0, 1);
    // Requester 2 streams without Last; requester 1 waits.
    add(1, 4'b0100, 4'b0000, 1, 4'b0000, 0, 0);
    for (int i = 0; i < 4; i++) add(0, 4'b0110, 4'b0000, 1, 4'b0100, 2, 1);
`ifdef MUX_ARB_HOLD_LIMIT_EN
    add(0, 4'b0110, 4'b0000, 1, 4'b0000, 2, 0);
    add(0, 4'b0110, 4'b0000, 1, 4'b0010, 1, 1);
`else
    add(0, 4'b0110, 4'b0000, 1, 4'b0100, 2, 1);
    add(0, 4'b0110, 4'b0000, 1, 4'b0100, 2, 1);
`endif

    Rst_n = 1'b1; Req = '0; Last = '0; Ready_in = 1'b0;
    #2;
    do_reset();
    #1;
    check("rst_gnt", 0, 32'(Gnt), 32'h0);
    check("rst_sel", 0, 32'(Sel), 32'h0);
    check("rst_vld", 0, 32'(Valid_out), 32'h0);

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].rst) do_reset();
      Req      = vecs[i].req;
      Last     = vecs[i].last;
      Ready_in = vecs[i].rdy;
      #1;
      check("vec_gnt", i, 32'(Gnt), 32'(vecs[i].gnt));
      check("vec_sel", i, 32'(Sel), 32'(vecs[i].sel));
      check("vec_vld", i, 32'(Valid_out), 32'(vecs[i].vld));
      if (vecs[i].vld) check("vec_data", i, 32'(Data_out), 32'(8'hA0 + vecs[i].sel));
      @(posedge Clk);
      #1;
    end

    // Asynchronous reset in the middle of a burst held by requester 1.
    do_reset();
    Req = 4'b0010; Last = 4'b0000; Ready_in = 1'b1;
    @(posedge Clk);
    #1;
    check("mid_pre_sel", 0, 32'(Sel), 32'h1);
    check("mid_pre_vld", 0, 32'(Valid_out), 32'h1);
    Rst_n = 1'b0;
    #1;
    check("mid_gnt", 0, 32'(Gnt), 32'h0);
    check("mid_sel", 0, 32'(Sel), 32'h0);
    check("mid_vld", 0, 32'(Valid_out), 32'h0);
    @(posedge Clk);
    #1;
    Rst_n = 1'b1; Req = 4'b1111; Last = 4'b1111;
    #1;
    check("mid_idle_gnt", 0, 32'(Gnt), 32'h0);
    @(posedge Clk);
    #1;
    check("mid_regrant_gnt", 0, 32'(Gnt), 32'h1);
    check("mid_regrant_sel", 0, 32'(Sel), 32'h0);

    // Random traffic against the reference model.
    do_reset();
    model_reset();
    for (int c = 0; c < 400; c++) begin
      Req      = 4'($urandom);
      Last     = 4'($urandom & $urandom);
      Ready_in = ($urandom_range(0, 3) != 0);
      Data_in  = 32'($urandom);
      #1;
      egnt = (m_gnt < 0) ? 4'b0000 : 4'(1 << m_gnt);
      evld = (m_gnt >= 0) && Req[m_gnt];
      check("rnd_gnt", c, 32'(Gnt), 32'(egnt));
      check("rnd_sel", c, 32'(Sel), 32'(m_sel));
      check("rnd_vld", c, 32'(Valid_out), 32'(evld));
      if (evld) check("rnd_data", c, 32'(Data_out), 32'(lane(m_sel)));
      model_step(Req, Last, Ready_in);
      @(posedge Clk);
      #1;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
